// File: rtl/hub75_scan.sv
`default_nettype none
// ============================================================================
// Module  : hub75_scan
// Brief   : HUB75 scan engine: frame-buffer fetch, dual-chain shift, BCM display.
// Rev     : 1.0  initial release
// ============================================================================
module hub75_scan #(
  parameter int COLS      = 32,
  parameter int ROW_BITS  = 3,
  parameter int BPC       = 4,
  parameter int SHIFT_DIV = 1,
  parameter int BASE_OE   = 4
) (
  input  logic                              osc_clk,
  input  logic                              osc_reset,
  input  logic                              enable,
  output logic                              rd_en,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  rd_addr,
  input  logic [6*BPC-1:0]                  rd_data,
  output logic                              hub75_clk,
  output logic                              hub75_lat,
  output logic                              hub75_oe_,
  output logic [ROW_BITS-1:0]               hub75_row,
  output logic                              hub75_r0,
  output logic                              hub75_g0,
  output logic                              hub75_b0,
  output logic                              hub75_r1,
  output logic                              hub75_g1,
  output logic                              hub75_b1,
  output logic                              frame_start
);

  localparam int c_COL_W    = $clog2(COLS);
  localparam int c_PL_W     = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int c_DISP_MAX = BASE_OE << (BPC - 1);
  localparam int c_CNT_MAX  = (c_DISP_MAX > SHIFT_DIV) ? c_DISP_MAX : SHIFT_DIV;
  localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_BLANK    = 3'd4,
    S_LATCH    = 3'd5,
    S_DISPLAY  = 3'd6
  } state_t;

  state_t               r_state;
  logic [ROW_BITS-1:0]  r_row;
  logic [c_PL_W-1:0]    r_plane;
  logic [c_COL_W-1:0]   r_col;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [BPC-1:0]       w_r0_f, w_g0_f, w_b0_f, w_r1_f, w_g1_f, w_b1_f;
  logic [c_CNT_W-1:0]   w_disp_last;
  logic                 w_shift_last;
  logic                 w_plane_last;
  logic [c_PL_W-1:0]    w_plane_nxt;
  logic [ROW_BITS-1:0]  w_row_nxt;
  logic [c_COL_W-1:0]   w_col_nxt;

  assign w_r0_f = rd_data[0*BPC +: BPC];
  assign w_g0_f = rd_data[1*BPC +: BPC];
  assign w_b0_f = rd_data[2*BPC +: BPC];
  assign w_r1_f = rd_data[3*BPC +: BPC];
  assign w_g1_f = rd_data[4*BPC +: BPC];
  assign w_b1_f = rd_data[5*BPC +: BPC];

  // BCM weighting: each plane displays twice as long as the one below it.
  assign w_disp_last  = (c_CNT_W'(BASE_OE) << r_plane) - c_CNT_W'(1);
  assign w_shift_last = (r_cnt == c_CNT_W'(SHIFT_DIV - 1));
  assign w_plane_last = (r_plane == c_PL_W'(BPC - 1));
  assign w_plane_nxt  = w_plane_last ? '0 : r_plane + 1'b1;
  assign w_row_nxt    = w_plane_last ? r_row + 1'b1 : r_row;
  assign w_col_nxt    = r_col + 1'b1;

  always_ff @(posedge osc_clk) begin
    if (osc_reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_plane     <= '0;
      r_col       <= '0;
      r_cnt       <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      frame_start <= 1'b0;
      hub75_clk   <= 1'b0;
      hub75_lat   <= 1'b0;
      hub75_oe_   <= 1'b1;
      hub75_row   <= '0;
      hub75_r0    <= 1'b0;
      hub75_g0    <= 1'b0;
      hub75_b0    <= 1'b0;
      hub75_r1    <= 1'b0;
      hub75_g1    <= 1'b0;
      hub75_b1    <= 1'b0;
    end else begin
      rd_en       <= 1'b0;
      frame_start <= 1'b0;
      hub75_lat   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          hub75_oe_ <= 1'b1;
          if (enable) begin
            r_state     <= S_FETCH;
            r_row       <= '0;
            r_plane     <= '0;
            r_col       <= '0;
            rd_en       <= 1'b1;
            rd_addr     <= '0;
            frame_start <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_SHIFT_LO;
          r_cnt   <= '0;
        end
        S_SHIFT_LO: begin
          // rd_data is valid only in the first low cycle, one after rd_en.
          if (r_cnt == '0) begin
            hub75_r0 <= w_r0_f[r_plane];
            hub75_g0 <= w_g0_f[r_plane];
            hub75_b0 <= w_b0_f[r_plane];
            hub75_r1 <= w_r1_f[r_plane];
            hub75_g1 <= w_g1_f[r_plane];
            hub75_b1 <= w_b1_f[r_plane];
          end
          if (w_shift_last) begin
            r_state   <= S_SHIFT_HI;
            r_cnt     <= '0;
            hub75_clk <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (w_shift_last) begin
            hub75_clk <= 1'b0;
            r_col     <= w_col_nxt;
            if (r_col == c_COL_W'(COLS - 1)) begin
              r_state   <= S_BLANK;
              hub75_row <= r_row;
            end else begin
              r_state <= S_FETCH;
              rd_en   <= 1'b1;
              rd_addr <= {r_row, w_col_nxt};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BLANK: begin
          r_state   <= S_LATCH;
          hub75_lat <= 1'b1;
        end
        S_LATCH: begin
          r_state   <= S_DISPLAY;
          hub75_oe_ <= 1'b0;
          r_cnt     <= '0;
        end
        S_DISPLAY: begin
          if (r_cnt == w_disp_last) begin
            hub75_oe_ <= 1'b1;
            if (enable) begin
              r_state     <= S_FETCH;
              r_row       <= w_row_nxt;
              r_plane     <= w_plane_nxt;
              rd_en       <= 1'b1;
              rd_addr     <= {w_row_nxt, c_COL_W'(0)};
              frame_start <= (w_row_nxt == '0) && (w_plane_nxt == '0);
            end else begin
              r_state <= S_IDLE;
              r_row   <= '0;
              r_plane <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_hub75_scan
// Brief   : Self-checking bench for hub75_scan against a period-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hub75_scan;

  localparam int COLS      = 4;
  localparam int ROW_BITS  = 1;
  localparam int BPC       = 2;
  localparam int SHIFT_DIV = 1;
  localparam int BASE_OE   = 4;
  localparam int AW        = ROW_BITS + 2;
  localparam int DW        = 6 * BPC;
  localparam int COL_PER   = 1 + 2 * SHIFT_DIV;
  localparam int SHIFT_LEN = COLS * COL_PER;
  localparam int RV        = 3 + ROW_BITS + 6 + 1 + AW + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b1;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [DW-1:0]       rd_data;
  logic                hclk, hlat, hoe;
  logic [ROW_BITS-1:0] hrow;
  logic                r0, g0, b0, r1, g1, b1;
  logic                fs;
  logic [DW-1:0]       mem [1<<AW];
  int                  n_vec = 0;
  int                  n_err = 0;

  typedef struct packed {
    logic                clk;
    logic                lat;
    logic                oe;
    logic                rden;
    logic                fs;
    logic [AW-1:0]       addr;
    logic [ROW_BITS-1:0] row;
    logic [5:0]          rgb;
  } exp_t;

  hub75_scan #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .BPC(BPC),
    .SHIFT_DIV(SHIFT_DIV), .BASE_OE(BASE_OE)
  ) dut (
    .osc_clk(clk), .osc_reset(rst), .enable(enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .hub75_clk(hclk), .hub75_lat(hlat), .hub75_oe_(hoe), .hub75_row(hrow),
    .hub75_r0(r0), .hub75_g0(g0), .hub75_b0(b0),
    .hub75_r1(r1), .hub75_g1(g1), .hub75_b1(b1),
    .frame_start(fs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Expected outputs k cycles after the first FETCH of a run, from the period formulas.
  function automatic exp_t model(input int k);
    exp_t e;
    int rowp, r, off, p, c, ph, a;
    logic [DW-1:0] w;
    rowp = 0;
    for (int i = 0; i < BPC; i++) rowp += SHIFT_LEN + 2 + (BASE_OE << i);
    r   = (k / rowp) % (1 << ROW_BITS);
    off = k % rowp;
    p   = 0;
    while (off >= SHIFT_LEN + 2 + (BASE_OE << p)) begin
      off -= SHIFT_LEN + 2 + (BASE_OE << p);
      p++;
    end
    e    = '0;
    e.oe = 1'b1;
    if (off >= SHIFT_LEN || p > 0) e.row = ROW_BITS'(r);
    else if (k >= SHIFT_LEN) e.row = ROW_BITS'((r + (1 << ROW_BITS) - 1) % (1 << ROW_BITS));
    if (off < SHIFT_LEN) begin
      c      = off / COL_PER;
      ph     = off % COL_PER;
      a      = r * COLS + c;
      w      = mem[a];
      e.rden = (ph == 0);
      e.addr = AW'(a);
      e.fs   = (ph == 0) && (a == 0) && (p == 0);
      e.clk  = (ph > SHIFT_DIV);
      e.rgb  = {w[p], w[BPC+p], w[2*BPC+p], w[3*BPC+p], w[4*BPC+p], w[5*BPC+p]};
    end else if (off == SHIFT_LEN + 1) begin
      e.lat = 1'b1;
    end else if (off >= SHIFT_LEN + 2) begin
      e.oe = 1'b0;
    end
    return e;
  endfunction

  task automatic start_run();
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [RV-1:0] obs, expv;
    rst    = 1'b1;
    enable = 1'b1;
    expv   = {3'b001, {ROW_BITS{1'b0}}, 6'b0, 1'b0, {AW{1'b0}}, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {hclk, hlat, hoe, hrow, r0, g0, b0, r1, g1, b1, rd_en, rd_addr, fs};
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL reset_values cycle=%0d got %b want %b", i, obs, expv);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({rd_en, fs, rd_addr} !== {1'b1, 1'b1, AW'(0)}) begin
      n_err++;
      $display("FAIL reset_first_fetch got rd_en/fs/addr=%b/%b/%0d want 1/1/0", rd_en, fs, rd_addr);
    end
  endtask

  task automatic test_shift_data();
    logic prev;
    int   edges;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0] = DW'(1);
    start_run();
    prev  = 1'b0;
    edges = 0;
    for (int k = 0; k < 2 * (SHIFT_LEN + 2) + 3 * BASE_OE; k++) begin
      if (k > 0) @(negedge clk);
      if (hclk === 1'b1 && !prev) begin
        n_vec++;
        if (r0 !== (edges == 0)) begin
          n_err++;
          $display("FAIL shift_r0 edge=%0d got %b want %b", edges, r0, (edges == 0));
        end
        edges++;
      end
      prev = hclk;
    end
    n_vec++;
    if (edges != 2 * COLS) begin
      n_err++;
      $display("FAIL shift_edges got %0d want %0d", edges, 2 * COLS);
    end
  endtask

  task automatic test_stream();
    exp_t e;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    start_run();
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      e = model(k);
      n_vec++;
      if ({hclk, hlat, hoe, hrow, rd_en, fs} !== {e.clk, e.lat, e.oe, e.row, e.rden, e.fs}) begin
        n_err++;
        $display("FAIL stream_ctrl k=%0d got clk/lat/oe/row/rden/fs=%b want %b", k,
                 {hclk, hlat, hoe, hrow, rd_en, fs}, {e.clk, e.lat, e.oe, e.row, e.rden, e.fs});
      end
      if (e.rden) begin
        n_vec++;
        if (rd_addr !== e.addr) begin
          n_err++;
          $display("FAIL stream_addr k=%0d got %0d want %0d", k, rd_addr, e.addr);
        end
      end
      if (e.clk) begin
        n_vec++;
        if ({r0, g0, b0, r1, g1, b1} !== e.rgb) begin
          n_err++;
          $display("FAIL stream_rgb k=%0d got %b want %b", k, {r0, g0, b0, r1, g1, b1}, e.rgb);
        end
      end
    end
  endtask

  // Continues straight after test_stream, which ends on a row boundary.
  task automatic test_bcm();
    int   run, nruns;
    logic prev_oe, prev_lat;
    run = 0; nruns = 0; prev_oe = 1'b1; prev_lat = 1'b0;
    for (int i = 0; i <= 80; i++) begin
      @(negedge clk);
      if (hclk === 1'b1) begin
        n_vec++;
        if (hoe !== 1'b1) begin
          n_err++;
          $display("FAIL bcm_oe_during_shift i=%0d got %b want 1", i, hoe);
        end
      end
      if (hoe === 1'b0 && prev_oe) begin
        n_vec++;
        if (prev_lat !== 1'b1) begin
          n_err++;
          $display("FAIL bcm_lat_before_oe i=%0d got %b want 1", i, prev_lat);
        end
      end
      if (hoe === 1'b0) run++;
      else if (!prev_oe) begin
        n_vec++;
        if (run != (BASE_OE << (nruns % BPC))) begin
          n_err++;
          $display("FAIL bcm_oe_len run=%0d got %0d want %0d", nruns, run, BASE_OE << (nruns % BPC));
        end
        nruns++;
        run = 0;
      end
      prev_oe  = hoe;
      prev_lat = hlat;
    end
    n_vec++;
    if (nruns != 2 * BPC) begin
      n_err++;
      $display("FAIL bcm_run_count got %0d want %0d", nruns, 2 * BPC);
    end
  endtask

  task automatic test_enable_drop();
    int nlow;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    start_run();
    nlow = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (hoe === 1'b0) nlow++;
      if (k >= SHIFT_LEN + 2 + BASE_OE) begin
        n_vec++;
        if (hoe !== 1'b1 || rd_en !== 1'b0 || fs !== 1'b0) begin
          n_err++;
          $display("FAIL drop_idle k=%0d got oe/rden/fs=%b%b%b want 100", k, hoe, rd_en, fs);
        end
      end
      if (k == 4) enable = 1'b0;
    end
    n_vec++;
    if (nlow != BASE_OE) begin
      n_err++;
      $display("FAIL drop_display_len got %0d want %0d", nlow, BASE_OE);
    end
    enable = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({rd_en, fs, rd_addr} !== {1'b1, 1'b1, AW'(0)}) begin
      n_err++;
      $display("FAIL drop_restart got rd_en/fs/addr=%b/%b/%0d want 1/1/0", rd_en, fs, rd_addr);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (hclk !== 1'b1) begin
      n_err++;
      $display("FAIL drop_restart_shift got hclk=%b want 1", hclk);
    end
  endtask

  task automatic test_reset_mid_display();
    logic found;
    logic [RV-1:0] obs, expv;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '1;
    start_run();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (hrow === ROW_BITS'(1) && hoe === 1'b0) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL middisp_wait got timeout want oe_=0 on row 1");
    end else begin
      n_vec++;
      if (r0 !== 1'b1) begin
        n_err++;
        $display("FAIL middisp_pre_r0 got %b want 1", r0);
      end
      rst = 1'b1;
      @(negedge clk);
      expv = {3'b001, {ROW_BITS{1'b0}}, 6'b0, 1'b0, {AW{1'b0}}, 1'b0};
      obs  = {hclk, hlat, hoe, hrow, r0, g0, b0, r1, g1, b1, rd_en, rd_addr, fs};
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL middisp_reset got %b want %b", obs, expv);
      end
      rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_shift_data();
    test_stream();
    test_bcm();
    test_enable_drop();
    test_reset_mid_display();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hub75_scan.md
# hub75_scan

Parametrised HUB75 scan engine for the LED cube panels. It fetches packed pixel words from a synchronous frame buffer and shifts them out over two colour chains, upper and lower half-panel. Brightness uses binary-code modulation (BCM) over BPC bit planes. It generalises the fixed 8-row, 3-bit-row-address panel driver inside CubeTop: column count, scan depth, colour depth, shift clock rate and BCM base period are all parameters, and the block adds enable/stop control and a frame_start marker.

## Interface
- COLS, 32: columns per chain; power of two, ≥2.
- ROW_BITS, 3: scan-row address width; 2^ROW_BITS scan rows.
- BPC, 4: bits per colour channel, which is also the number of BCM planes; 1..8.
- SHIFT_DIV, 1: hub75_clk half-period in osc_clk cycles; ≥1.
- BASE_OE, 4: oe_ low cycles for plane 0; ≥1.
- osc_clk  in  1  sole clock; all logic on the rising edge.
- osc_reset  in  1  synchronous, active-high reset.
- enable  in  1  run the scan; sampled at plane boundaries.
- rd_en  out  1  frame-buffer read strobe.
- rd_addr  out  ROW_BITS+log2(COLS)  {row, col}.
- rd_data  in  6*BPC  {b1,g1,r1,b0,g0,r0}, each BPC bits; valid exactly 1 cycle after rd_en.
- hub75_clk  out  1  panel shift clock.
- hub75_lat  out  1  panel latch.
- hub75_oe_  out  1  panel output enable, active low.
- hub75_row  out  ROW_BITS  scan-row address.
- hub75_r0/g0/b0, hub75_r1/g1/b1  out  1 each  colour data for the upper and lower chains.
- frame_start  out  1  one-cycle pulse at the start of row 0, plane 0.

## Operation
- Reset values: hub75_clk 0, hub75_lat 0, hub75_oe_ 1, hub75_row 0, all colour bits 0, rd_en 0, rd_addr 0, frame_start 0. The FSM resets to IDLE with row=0 and plane=0.
- FSM states: IDLE → FETCH → SHIFT_LO → SHIFT_HI → (next column: FETCH | last column: BLANK) → LATCH → DISPLAY → (FETCH | IDLE).
- IDLE: oe_=1. When enable=1, go to FETCH with row=0, plane=0, col=0.
- FETCH (1 cycle): rd_en=1, rd_addr={row,col}. frame_start=1 in this cycle when row=0, plane=0, col=0.
- SHIFT_LO (SHIFT_DIV cycles): hub75_clk=0. In its first cycle, register the colour bits: hub75_r0 = rd_data[plane] (r0 field), and likewise for every field at bit index `plane`. The registered bits hold through SHIFT_HI.
- SHIFT_HI (SHIFT_DIV cycles): hub75_clk=1. The panel samples on the rising edge.
- After SHIFT_HI: col++. If col wraps to 0, go to BLANK, else go to FETCH.
- BLANK (1 cycle): hub75_clk=0, oe_=1. hub75_row takes the current row in this cycle.
- LATCH (1 cycle): hub75_lat=1.
- DISPLAY (BASE_OE<<plane cycles): hub75_oe_=0.
- On leaving DISPLAY:
  - plane++.
  - When plane wraps from BPC-1 to 0, row++; row wraps from 2^ROW_BITS-1 to 0.
  - If enable=0, go to IDLE (row and plane reset to 0). Otherwise go to FETCH.
- hub75_oe_ is 1 in every state except DISPLAY. hub75_lat is 1 only in LATCH. Colour outputs hold their last value outside SHIFT.
- Deasserting enable never truncates a plane: the current plane completes, including its DISPLAY time.
- osc_reset mid-operation: on the next edge, all outputs and state return to reset values regardless of state. oe_ rises to 1 in that same edge.
- Counters: col is log2(COLS) bits and wraps naturally. The DISPLAY counter must be wide enough for BASE_OE<<(BPC-1).

## Timing
- Read latency: 1 cycle. No backpressure on the frame buffer; rd_data is sampled blindly.
- Column period: 1+2*SHIFT_DIV cycles.
- Plane period for plane p: COLS*(1+2*SHIFT_DIV) + 2 + (BASE_OE<<p).
- Row period: sum of the plane periods for p = 0..BPC-1.
- Frame period: 2^ROW_BITS × row period.
- frame_start spacing equals the frame period while enable stays 1.
- First rd_en after enable rises from IDLE: the cycle after enable is sampled high.

## Test plan
All scenarios use the small configuration COLS=4, ROW_BITS=1, BPC=2, SHIFT_DIV=1, BASE_OE=4, giving plane periods of 18 and 22 cycles, a row period of 40 and a frame period of 80.
- Reset: hold osc_reset for 3 cycles with enable=1 → outputs at reset values throughout; first FETCH one cycle after reset drops, with frame_start=1 and rd_addr=0.
- Shift data: the memory returns r0 field 2'b01 for col 0 and 0 elsewhere → on row 0, plane 0, hub75_r0=1 at the first of 4 hub75_clk rising edges; on plane 1, hub75_r0=0 at all 4 edges.
- BCM: measure hub75_oe_ low → 4 cycles in plane 0 and 8 cycles in plane 1, each immediately after a 1-cycle hub75_lat pulse; oe_=1 during every hub75_clk toggle.
- Row and frame wrap: run 200 cycles → hub75_row sequence 0,1,0 changing only in BLANK; frame_start pulses exactly 80 cycles apart.
- Enable drop: deassert enable during col 1 of plane 0 → plane 0 completes its 4-cycle DISPLAY, then IDLE with oe_=1 and no further rd_en. Reassert enable → restart at row 0, plane 0 with frame_start.
- Reset mid-DISPLAY: assert osc_reset while oe_=0 → next cycle oe_=1, hub75_row=0, colour outputs 0.
